cpu_control: RTL and testbench

- Control block for the 5-stage pipelined LEGv8 CPU.
- Contains three parts:
  - the main opcode decoder (ID-stage control signals);
  - the ALU-operation decoder;
  - the EX/MEM pipeline register, which carries MEM/WB control bits, the destination register, the EX result and the store data into the MEM stage.
- The decoders are combinational. The EX/MEM register is clocked.

---
 rtl/cpu_pkg.sv | 64 ++++++
 rtl/ex_mem_reg.sv | 63 ++++++
 rtl/cpu_control.sv | 195 +++++++++++++++++++
 tb/tb_cpu_control.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the LEGv8 pipeline control block: opcode patterns,
// instruction classes, ALU operation and forwarding-class encodings.
package cpu_pkg;

  localparam logic [10:0] OP_B      = 11'b00010100000;
  localparam logic [10:0] OP_BL     = 11'b10010100000;
  localparam logic [10:0] OP_BCOND  = 11'b01010100000;
  localparam logic [10:0] OP_CBZ    = 11'b10110100000;
  localparam logic [10:0] OP_ADDI   = 11'b10010001000;
  localparam logic [10:0] OP_ADDS   = 11'b10101011000;
  localparam logic [10:0] OP_SUBS   = 11'b11101011000;
  localparam logic [10:0] OP_AND    = 11'b10001010000;
  localparam logic [10:0] OP_EOR    = 11'b11001010000;
  localparam logic [10:0] OP_LSL    = 11'b11010011011;
  localparam logic [10:0] OP_LSR    = 11'b11010011010;
  localparam logic [10:0] OP_LDUR   = 11'b11111000010;
  localparam logic [10:0] OP_STUR   = 11'b11111000000;
  localparam logic [10:0] OP_BR     = 11'b11010110000;

  localparam logic [10:0] MASK_6    = 11'b11111100000;
  localparam logic [10:0] MASK_8    = 11'b11111111000;
  localparam logic [10:0] MASK_10   = 11'b11111111110;
  localparam logic [10:0] MASK_FULL = 11'b11111111111;

  localparam logic [2:0] ALU_PASSB = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b011;
  localparam logic [2:0] ALU_AND   = 3'b100;
  localparam logic [2:0] ALU_XOR   = 3'b110;

  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_I     = 2'b10;
  localparam logic [1:0] FWD_R     = 2'b11;

  typedef enum logic [3:0] {
    InsNop, InsB, InsBl, InsBcond, InsCbz, InsAddi, InsAdds, InsSubs,
    InsAnd, InsEor, InsLsl, InsLsr, InsLdur, InsStur, InsBr
  } insn_e;

  typedef struct packed {
    logic       uncond_br;
    logic       branch;
    logic       reg2loc;
    logic       alu_src;
    logic       reg_write;
    logic       alu_sh;
    logic       imm;
    logic       mem_to_reg;
    logic       mem_write;
    logic       mem_read;
    logic       shift_dirn;
    logic       alu_on;
    logic       set_flags;
    logic       branch_reg;
    logic       branch_link;
    logic [1:0] fwd_en;
  } ctrl_t;

  function automatic logic op_match(input logic [10:0] op, input logic [10:0] pat,
                                    input logic [10:0] mask);
    return (op & mask) == (pat & mask);
  endfunction

endpackage

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: loads every cycle, synchronous active-high reset.
// Optional control-bit squash enabled by CPU_CONTROL_FLUSH_EN.
module ex_mem_reg
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
`ifdef CPU_CONTROL_FLUSH_EN
  input  logic              flush_i,
`endif
  input  logic              mem_to_reg_i,
  input  logic              mem_write_i,
  input  logic              mem_read_i,
  input  logic              branch_link_i,
  input  logic              reg_write_i,
  input  logic [REG_W-1:0]  target_reg_i,
  input  logic [DATA_W-1:0] to_data_mem_i,
  input  logic [DATA_W-1:0] alu_b_i,
  output logic              mem_to_reg_o,
  output logic              mem_write_o,
  output logic              mem_read_o,
  output logic              branch_link_o,
  output logic              reg_write_o,
  output logic [REG_W-1:0]  target_reg_o,
  output logic [DATA_W-1:0] to_data_mem_o,
  output logic [DATA_W-1:0] alu_b_o
);

  logic [4:0]        ctrl_d, ctrl_q;
  logic [REG_W-1:0]  target_reg_q;
  logic [DATA_W-1:0] to_data_mem_q, alu_b_q;

  always_comb begin
    ctrl_d = {mem_to_reg_i, mem_write_i, mem_read_i, branch_link_i, reg_write_i};
`ifdef CPU_CONTROL_FLUSH_EN
    // A flushed instruction keeps its data but loses every side effect.
    if (flush_i) ctrl_d = '0;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q        <= '0;
      target_reg_q  <= '0;
      to_data_mem_q <= '0;
      alu_b_q       <= '0;
    end else begin
      ctrl_q        <= ctrl_d;
      target_reg_q  <= target_reg_i;
      to_data_mem_q <= to_data_mem_i;
      alu_b_q       <= alu_b_i;
    end
  end

  assign {mem_to_reg_o, mem_write_o, mem_read_o, branch_link_o, reg_write_o} = ctrl_q;
  assign target_reg_o  = target_reg_q;
  assign to_data_mem_o = to_data_mem_q;
  assign alu_b_o       = alu_b_q;

endmodule

// File: rtl/cpu_control.sv
// LEGv8 5-stage pipeline control: ID-stage main/ALU decoders plus EX/MEM register.
// Optional flush_EX input enabled by CPU_CONTROL_FLUSH_EN.
module cpu_control
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
`ifdef CPU_CONTROL_FLUSH_EN
  input  logic              flush_EX,
`endif
  input  logic [10:0]       opcode,
  input  logic              sign,
  output logic              uncondBr,
  output logic              branch,
  output logic              Reg2Loc,
  output logic              ALU_Src,
  output logic              RegWrite,
  output logic              ALU_SH,
  output logic              Imm,
  output logic              memToReg,
  output logic              memWrite,
  output logic              memRead,
  output logic              shiftDirn,
  output logic              ALU_on,
  output logic              set_flags,
  output logic              branchReg,
  output logic              branchLink,
  output logic [1:0]        fwdEn,
  output logic [2:0]        ALU_cntrl,
  input  logic              memToReg_EX,
  input  logic              memWrite_EX,
  input  logic              memRead_EX,
  input  logic              branchLink_EX,
  input  logic              RegWrite_EX,
  input  logic [REG_W-1:0]  targetReg_EX,
  input  logic [DATA_W-1:0] toDataMem,
  input  logic [DATA_W-1:0] ALU_B,
  output logic              memToReg_MEM,
  output logic              memWrite_MEM,
  output logic              memRead_MEM,
  output logic              branchLink_MEM,
  output logic              RegWrite_MEM,
  output logic [REG_W-1:0]  targetReg_MEM,
  output logic [DATA_W-1:0] toDataMem_MEM,
  output logic [DATA_W-1:0] ALU_B_MEM
);

  insn_e      insn;
  ctrl_t      ctrl;
  logic [2:0] alu_op;

  // Patterns are disjoint, so the order of this chain does not matter.
  always_comb begin
    insn = InsNop;
    if      (op_match(opcode, OP_B,     MASK_6))    insn = InsB;
    else if (op_match(opcode, OP_BL,    MASK_6))    insn = InsBl;
    else if (op_match(opcode, OP_BCOND, MASK_8))    insn = InsBcond;
    else if (op_match(opcode, OP_CBZ,   MASK_8))    insn = InsCbz;
    else if (op_match(opcode, OP_ADDI,  MASK_10))   insn = InsAddi;
    else if (op_match(opcode, OP_ADDS,  MASK_FULL)) insn = InsAdds;
    else if (op_match(opcode, OP_SUBS,  MASK_FULL)) insn = InsSubs;
    else if (op_match(opcode, OP_AND,   MASK_FULL)) insn = InsAnd;
    else if (op_match(opcode, OP_EOR,   MASK_FULL)) insn = InsEor;
    else if (op_match(opcode, OP_LSL,   MASK_FULL)) insn = InsLsl;
    else if (op_match(opcode, OP_LSR,   MASK_FULL)) insn = InsLsr;
    else if (op_match(opcode, OP_LDUR,  MASK_FULL)) insn = InsLdur;
    else if (op_match(opcode, OP_STUR,  MASK_FULL)) insn = InsStur;
    else if (op_match(opcode, OP_BR,    MASK_FULL)) insn = InsBr;
  end

  always_comb begin
    ctrl = '0;
    if (!rst) begin
      unique case (insn)
        InsAdds, InsSubs, InsAnd, InsEor: begin
          ctrl.reg2loc   = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.alu_on    = 1'b1;
          ctrl.fwd_en    = FWD_R;
          ctrl.set_flags = (insn == InsAdds) || (insn == InsSubs);
        end
        InsAddi: begin
          ctrl.alu_src   = 1'b1;
          ctrl.imm       = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.alu_on    = 1'b1;
          ctrl.fwd_en    = FWD_I;
        end
        InsLsl, InsLsr: begin
          ctrl.alu_sh     = 1'b1;
          ctrl.reg_write  = 1'b1;
          ctrl.fwd_en     = FWD_I;
          ctrl.shift_dirn = (insn == InsLsr);
        end
        InsLdur: begin
          ctrl.alu_src    = 1'b1;
          ctrl.mem_read   = 1'b1;
          ctrl.mem_to_reg = 1'b1;
          ctrl.reg_write  = 1'b1;
          ctrl.alu_on     = 1'b1;
        end
        InsStur: begin
          ctrl.alu_src   = 1'b1;
          ctrl.mem_write = 1'b1;
          ctrl.alu_on    = 1'b1;
        end
        InsB: begin
          ctrl.branch    = 1'b1;
          ctrl.uncond_br = 1'b1;
        end
        InsBl: begin
          ctrl.branch      = 1'b1;
          ctrl.uncond_br   = 1'b1;
          ctrl.branch_link = 1'b1;
          ctrl.reg_write   = 1'b1;
          ctrl.alu_on      = 1'b1;
        end
        InsBcond: ctrl.branch = 1'b1;
        InsCbz: begin
          ctrl.branch = 1'b1;
          ctrl.alu_on = 1'b1;
        end
        InsBr: begin
          ctrl.branch     = 1'b1;
          ctrl.branch_reg = 1'b1;
        end
        default: ctrl = '0;
      endcase
    end
  end

  // Loads/stores subtract when the DAddr9 offset is negative.
  always_comb begin
    alu_op = ALU_PASSB;
    if (!rst) begin
      unique case (insn)
        InsAddi, InsAdds: alu_op = ALU_ADD;
        InsSubs:          alu_op = ALU_SUB;
        InsAnd:           alu_op = ALU_AND;
        InsEor:           alu_op = ALU_XOR;
        InsLdur, InsStur: alu_op = sign ? ALU_SUB : ALU_ADD;
        default:          alu_op = ALU_PASSB;
      endcase
    end
  end

  assign uncondBr   = ctrl.uncond_br;
  assign branch     = ctrl.branch;
  assign Reg2Loc    = ctrl.reg2loc;
  assign ALU_Src    = ctrl.alu_src;
  assign RegWrite   = ctrl.reg_write;
  assign ALU_SH     = ctrl.alu_sh;
  assign Imm        = ctrl.imm;
  assign memToReg   = ctrl.mem_to_reg;
  assign memWrite   = ctrl.mem_write;
  assign memRead    = ctrl.mem_read;
  assign shiftDirn  = ctrl.shift_dirn;
  assign ALU_on     = ctrl.alu_on;
  assign set_flags  = ctrl.set_flags;
  assign branchReg  = ctrl.branch_reg;
  assign branchLink = ctrl.branch_link;
  assign fwdEn      = ctrl.fwd_en;
  assign ALU_cntrl  = alu_op;

  ex_mem_reg #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_ex_mem_reg (
    .clk_i         (clk),
    .rst_i         (rst),
`ifdef CPU_CONTROL_FLUSH_EN
    .flush_i       (flush_EX),
`endif
    .mem_to_reg_i  (memToReg_EX),
    .mem_write_i   (memWrite_EX),
    .mem_read_i    (memRead_EX),
    .branch_link_i (branchLink_EX),
    .reg_write_i   (RegWrite_EX),
    .target_reg_i  (targetReg_EX),
    .to_data_mem_i (toDataMem),
    .alu_b_i       (ALU_B),
    .mem_to_reg_o  (memToReg_MEM),
    .mem_write_o   (memWrite_MEM),
    .mem_read_o    (memRead_MEM),
    .branch_link_o (branchLink_MEM),
    .reg_write_o   (RegWrite_MEM),
    .target_reg_o  (targetReg_MEM),
    .to_data_mem_o (toDataMem_MEM),
    .alu_b_o       (ALU_B_MEM)
  );

endmodule

// File: tb/tb_cpu_control.sv
// Directed bench for cpu_control: decoder vectors and EX/MEM register timing.
// Decoder vector order: uncondBr,branch,Reg2Loc,ALU_Src,RegWrite,ALU_SH,Imm,memToReg,
// memWrite,memRead,shiftDirn,ALU_on,set_flags,branchReg,branchLink | fwdEn | ALU_cntrl.
module tb_cpu_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] opcode;
  logic        sign;
  logic        uncondBr, branch, Reg2Loc, ALU_Src, RegWrite, ALU_SH, Imm, memToReg;
  logic        memWrite, memRead, shiftDirn, ALU_on, set_flags, branchReg, branchLink;
  logic [1:0]  fwdEn;
  logic [2:0]  ALU_cntrl;
  logic        memToReg_EX, memWrite_EX, memRead_EX, branchLink_EX, RegWrite_EX;
  logic [4:0]  targetReg_EX;
  logic [63:0] toDataMem, ALU_B;
  logic        memToReg_MEM, memWrite_MEM, memRead_MEM, branchLink_MEM, RegWrite_MEM;
  logic [4:0]  targetReg_MEM;
  logic [63:0] toDataMem_MEM, ALU_B_MEM;
`ifdef CPU_CONTROL_FLUSH_EN
  logic        flush_EX = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  cpu_control #(.DATA_W(64), .REG_W(5)) dut (
    .clk            (clk),
    .rst            (rst),
`ifdef CPU_CONTROL_FLUSH_EN
    .flush_EX       (flush_EX),
`endif
    .opcode         (opcode),
    .sign           (sign),
    .uncondBr       (uncondBr),
    .branch         (branch),
    .Reg2Loc        (Reg2Loc),
    .ALU_Src        (ALU_Src),
    .RegWrite       (RegWrite),
    .ALU_SH         (ALU_SH),
    .Imm            (Imm),
    .memToReg       (memToReg),
    .memWrite       (memWrite),
    .memRead        (memRead),
    .shiftDirn      (shiftDirn),
    .ALU_on         (ALU_on),
    .set_flags      (set_flags),
    .branchReg      (branchReg),
    .branchLink     (branchLink),
    .fwdEn          (fwdEn),
    .ALU_cntrl      (ALU_cntrl),
    .memToReg_EX    (memToReg_EX),
    .memWrite_EX    (memWrite_EX),
    .memRead_EX     (memRead_EX),
    .branchLink_EX  (branchLink_EX),
    .RegWrite_EX    (RegWrite_EX),
    .targetReg_EX   (targetReg_EX),
    .toDataMem      (toDataMem),
    .ALU_B          (ALU_B),
    .memToReg_MEM   (memToReg_MEM),
    .memWrite_MEM   (memWrite_MEM),
    .memRead_MEM    (memRead_MEM),
    .branchLink_MEM (branchLink_MEM),
    .RegWrite_MEM   (RegWrite_MEM),
    .targetReg_MEM  (targetReg_MEM),
    .toDataMem_MEM  (toDataMem_MEM),
    .ALU_B_MEM      (ALU_B_MEM)
  );

  always #5 clk = ~clk;

  logic [19:0]  dec_obs;
  logic [137:0] mem_obs;
  assign dec_obs = {uncondBr, branch, Reg2Loc, ALU_Src, RegWrite, ALU_SH, Imm, memToReg,
                    memWrite, memRead, shiftDirn, ALU_on, set_flags, branchReg, branchLink,
                    fwdEn, ALU_cntrl};
  assign mem_obs = {memToReg_MEM, memWrite_MEM, memRead_MEM, branchLink_MEM, RegWrite_MEM,
                    targetReg_MEM, toDataMem_MEM, ALU_B_MEM};

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic dec(input string tag, input logic [10:0] op, input logic s,
                     input logic [19:0] exp);
    opcode = op;
    sign   = s;
    #1;
    chk(tag, {140'd0, dec_obs}, {140'd0, exp});
  endtask

  task automatic drive_ex(input logic [4:0] ctl, input logic [4:0] tgt,
                          input logic [63:0] d, input logic [63:0] b);
    {memToReg_EX, memWrite_EX, memRead_EX, branchLink_EX, RegWrite_EX} = ctl;
    targetReg_EX = tgt;
    toDataMem    = d;
    ALU_B        = b;
  endtask

  initial begin
    rst    = 1'b1;
    opcode = 11'b10101011000;
    sign   = 1'b1;
    drive_ex(5'b11111, 5'd31, 64'hDEAD_BEEF_0000_0001, 64'hCAFE);
    #1;
    chk("rst_decoder", {140'd0, dec_obs}, 160'd0);
    @(posedge clk); #1;
    chk("rst_mem", {22'd0, mem_obs}, 160'd0);
    rst = 1'b0;

    dec("adds",      11'b10101011000, 1'b0, 20'b00101_00000_01100_11_010);
    dec("subs",      11'b11101011000, 1'b0, 20'b00101_00000_01100_11_011);
    dec("and",       11'b10001010000, 1'b0, 20'b00101_00000_01000_11_100);
    dec("eor",       11'b11001010000, 1'b1, 20'b00101_00000_01000_11_110);
    dec("addi",      11'b10010001001, 1'b1, 20'b00011_01000_01000_10_010);
    dec("lsl",       11'b11010011011, 1'b0, 20'b00001_10000_00000_10_000);
    dec("lsr",       11'b11010011010, 1'b0, 20'b00001_10000_10000_10_000);
    dec("ldur_neg",  11'b11111000010, 1'b1, 20'b00011_00101_01000_00_011);
    dec("ldur_pos",  11'b11111000010, 1'b0, 20'b00011_00101_01000_00_010);
    dec("stur_pos",  11'b11111000000, 1'b0, 20'b00010_00010_01000_00_010);
    dec("b",         11'b00010110101, 1'b0, 20'b11000_00000_00000_00_000);
    dec("bl",        11'b10010111011, 1'b1, 20'b11001_00000_01001_00_000);
    dec("bcond",     11'b01010100111, 1'b0, 20'b01000_00000_00000_00_000);
    dec("cbz",       11'b10110100101, 1'b1, 20'b01000_00000_01000_00_000);
    dec("br",        11'b11010110000, 1'b0, 20'b01000_00000_00010_00_000);
    dec("nop_zero",  11'b00000000000, 1'b1, 20'd0);
    dec("nop_near",  11'b11111000011, 1'b1, 20'd0);

    // Register: one-cycle latency, stable until the next edge.
    @(negedge clk);
    drive_ex(5'b00001, 5'd7, 64'h1234, 64'hFF);
    @(posedge clk); #1;
    chk("mem_load", {22'd0, mem_obs}, {22'd0, 5'b00001, 5'd7, 64'h1234, 64'hFF});
    drive_ex(5'b11110, 5'd19, 64'hA5A5_0000_FFFF_1111, 64'h0123_4567_89AB_CDEF);
    @(negedge clk);
    chk("mem_hold", {22'd0, mem_obs}, {22'd0, 5'b00001, 5'd7, 64'h1234, 64'hFF});
    @(posedge clk); #1;
    chk("mem_load2", {22'd0, mem_obs},
        {22'd0, 5'b11110, 5'd19, 64'hA5A5_0000_FFFF_1111, 64'h0123_4567_89AB_CDEF});

    // Mid-stream reset drops the in-flight store.
    drive_ex(5'b01000, 5'd3, 64'h55, 64'h66);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mem_rst_mid", {22'd0, mem_obs}, 160'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mem_after_rst", {22'd0, mem_obs}, {22'd0, 5'b01000, 5'd3, 64'h55, 64'h66});

`ifdef CPU_CONTROL_FLUSH_EN
    drive_ex(5'b11111, 5'd12, 64'h9999, 64'h7777);
    flush_EX = 1'b1;
    @(posedge clk); #1;
    chk("mem_flush", {22'd0, mem_obs}, {22'd0, 5'b00000, 5'd12, 64'h9999, 64'h7777});
    flush_EX = 1'b0;
    @(posedge clk); #1;
    chk("mem_unflush", {22'd0, mem_obs}, {22'd0, 5'b11111, 5'd12, 64'h9999, 64'h7777});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
